// File: rtl/lram_bank_pkg.sv
// Shared types and defaults for the LRAM bank controller.
// Configuration macro: LRAM_BANK_OUTREG_EN (adds a response output register).
package lram_bank_pkg;

  localparam int unsigned LRAM_TILE_DEPTH_DEFAULT = 16384;
  localparam int unsigned LRAM_DATA_W_DEFAULT     = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Read latency in cycles from accept edge to the edge that raises rsp_valid.
  function automatic int unsigned rd_latency();
`ifdef LRAM_BANK_OUTREG_EN
    return 3;
`else
    return 2;
`endif
  endfunction

endpackage

// File: rtl/lram_tile.sv
// One large-RAM tile: synchronous read, byte-enabled write, single port.
// Ports: clk, en (access strobe), we (1 = write), addr (word), wdata, be
// (byte enables), rdata (registered read data, updated on read accesses only).
module lram_tile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16384,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned BW    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BW-1:0]     be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array has no reset; contents are cleared by the controller.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < int'(BW); b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lram_bank_ctrl.sv
// Stitches TILES lram_tile instances into one flat byte-writable memory.
// Clears all tiles after reset (INIT), then serves one request per cycle (RUN).
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_we/req_addr/
// req_wdata/req_be request port; rsp_valid/rsp_rdata/rsp_err read response;
// wr_err out-of-range write pulse; init_done.
// Configuration macro: LRAM_BANK_OUTREG_EN adds one response register stage.
module lram_bank_ctrl
  import lram_bank_pkg::*;
#(
  parameter int unsigned DATA_W     = LRAM_DATA_W_DEFAULT,
  parameter int unsigned TILES      = 2,
  parameter int unsigned TILE_DEPTH = LRAM_TILE_DEPTH_DEFAULT,
  parameter int unsigned DEPTH_USED = TILES * TILE_DEPTH,
  localparam int unsigned AW        = $clog2(TILES * TILE_DEPTH),
  localparam int unsigned BW        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BW-1:0]     req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr_err,
  output logic              init_done
);

  localparam int unsigned OFFW = $clog2(TILE_DEPTH);
  localparam int unsigned TSW  = (TILES > 1) ? $clog2(TILES) : 1;

  state_e            state_q, state_d;
  logic [OFFW-1:0]   ctr_q, ctr_d;
  logic              req_ready_q, req_ready_d, init_done_q, init_done_d;
  logic              s1_valid_q, s1_valid_d, s1_we_q, s1_we_d, s1_inr_q, s1_inr_d;
  logic [TSW-1:0]    s1_tile_q, s1_tile_d, s2_tile_q, s2_tile_d;
  logic [OFFW-1:0]   s1_off_q, s1_off_d;
  logic [DATA_W-1:0] s1_wdata_q, s1_wdata_d;
  logic [BW-1:0]     s1_be_q, s1_be_d;
  logic              s2_rd_q, s2_rd_d, s2_err_q, s2_err_d;
  logic              wr_err_q, wr_err_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef LRAM_BANK_OUTREG_EN
  logic              o_valid_q, o_valid_d, o_err_q, o_err_d;
  logic [DATA_W-1:0] o_rdata_q, o_rdata_d;
`endif

  logic [TILES-1:0]  tile_en;
  logic              tile_we;
  logic [OFFW-1:0]   tile_addr;
  logic [DATA_W-1:0] tile_wdata;
  logic [BW-1:0]     tile_be;
  logic [DATA_W-1:0] tile_rdata [TILES];
  logic [DATA_W-1:0] rd_mux;

  for (genvar t = 0; t < int'(TILES); t++) begin : g_tile
    lram_tile #(.DATA_W(DATA_W), .DEPTH(TILE_DEPTH)) u_tile (
      .clk   (clk),
      .en    (tile_en[t]),
      .we    (tile_we),
      .addr  (tile_addr),
      .wdata (tile_wdata),
      .be    (tile_be),
      .rdata (tile_rdata[t])
    );
  end

  // Tile port drive: broadcast zero-fill in INIT, decoded stage-1 access in RUN.
  always_comb begin
    tile_en    = '0;
    tile_we    = 1'b1;
    tile_addr  = ctr_q;
    tile_wdata = '0;
    tile_be    = '1;
    if (state_q == INIT) begin
      tile_en = '1;
    end else begin
      tile_we    = s1_we_q;
      tile_addr  = s1_off_q;
      tile_wdata = s1_wdata_q;
      tile_be    = s1_be_q;
      for (int t = 0; t < int'(TILES); t++) begin
        tile_en[t] = s1_valid_q & s1_inr_q & (s1_tile_q == TSW'(t));
      end
    end
  end

  // Out-of-range reads return zero rather than any tile's stale register.
  always_comb begin
    rd_mux = '0;
    if (!s2_err_q) begin
      for (int t = 0; t < int'(TILES); t++) begin
        if (s2_tile_q == TSW'(t)) rd_mux = tile_rdata[t];
      end
    end
  end

  // Next-state: FSM, request pipeline and response path.
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    req_ready_d = req_ready_q;
    init_done_d = init_done_q;
    s1_valid_d  = req_valid & req_ready_q;
    s1_we_d     = s1_we_q;
    s1_inr_d    = s1_inr_q;
    s1_tile_d   = s1_tile_q;
    s1_off_d    = s1_off_q;
    s1_wdata_d  = s1_wdata_q;
    s1_be_d     = s1_be_q;
    s2_rd_d     = s1_valid_q & ~s1_we_q;
    s2_err_d    = ~s1_inr_q;
    s2_tile_d   = s1_tile_q;
    wr_err_d    = s1_valid_q & s1_we_q & ~s1_inr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef LRAM_BANK_OUTREG_EN
    o_valid_d   = s2_rd_q;
    o_rdata_d   = o_rdata_q;
    o_err_d     = o_err_q;
`endif

    unique case (state_q)
      INIT: begin
        ctr_d = ctr_q + OFFW'(1);
        if (ctr_q == OFFW'(TILE_DEPTH - 1)) begin
          state_d     = RUN;
          req_ready_d = 1'b1;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        req_ready_d = 1'b1;
        init_done_d = 1'b1;
      end
      default: state_d = INIT;
    endcase

    if (req_valid && req_ready_q) begin
      s1_we_d    = req_we;
      s1_inr_d   = 32'(req_addr) < DEPTH_USED;
      s1_tile_d  = TSW'(req_addr >> OFFW);
      s1_off_d   = req_addr[OFFW-1:0];
      s1_wdata_d = req_wdata;
      s1_be_d    = req_be;
    end

`ifdef LRAM_BANK_OUTREG_EN
    if (s2_rd_q) begin
      o_rdata_d = rd_mux;
      o_err_d   = s2_err_q;
    end
    rsp_valid_d = o_valid_q;
    if (o_valid_q) begin
      rsp_rdata_d = o_rdata_q;
      rsp_err_d   = o_err_q;
    end
`else
    rsp_valid_d = s2_rd_q;
    if (s2_rd_q) begin
      rsp_rdata_d = rd_mux;
      rsp_err_d   = s2_err_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      ctr_q       <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_we_q     <= 1'b0;
      s1_inr_q    <= 1'b0;
      s1_tile_q   <= '0;
      s1_off_q    <= '0;
      s1_wdata_q  <= '0;
      s1_be_q     <= '0;
      s2_rd_q     <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_tile_q   <= '0;
      wr_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef LRAM_BANK_OUTREG_EN
      o_valid_q   <= 1'b0;
      o_rdata_q   <= '0;
      o_err_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      req_ready_q <= req_ready_d;
      init_done_q <= init_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_we_q     <= s1_we_d;
      s1_inr_q    <= s1_inr_d;
      s1_tile_q   <= s1_tile_d;
      s1_off_q    <= s1_off_d;
      s1_wdata_q  <= s1_wdata_d;
      s1_be_q     <= s1_be_d;
      s2_rd_q     <= s2_rd_d;
      s2_err_q    <= s2_err_d;
      s2_tile_q   <= s2_tile_d;
      wr_err_q    <= wr_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef LRAM_BANK_OUTREG_EN
      o_valid_q   <= o_valid_d;
      o_rdata_q   <= o_rdata_d;
      o_err_q     <= o_err_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign wr_err    = wr_err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lram_bank_ctrl.sv
// Self-checking bench for lram_bank_ctrl (DATA_W=32, TILES=3, TILE_DEPTH=16).
module tb_lram_bank_ctrl;
  import lram_bank_pkg::*;

  localparam int unsigned LAT = rd_latency();

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err, wr_err, init_done;
  logic [31:0] rsp_rdata;

  lram_bank_ctrl #(.DATA_W(32), .TILES(3), .TILE_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wr_err(wr_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t rq[$];
  int   wq[$];

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Scoreboard: compare responses and write-error pulses against queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (rq.size() == 0 || rq[0].due != cyc) begin
          chk("unexpected_rsp_valid", 32'(rsp_valid), 32'(0));
        end else begin
          chk("rsp_rdata", rsp_rdata, rq[0].rdata);
          chk("rsp_err", 32'(rsp_err), 32'(rq[0].err));
          void'(rq.pop_front());
        end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        chk("missing_rsp_valid", 32'(rsp_valid), 32'(1));
        void'(rq.pop_front());
      end
      if (wr_err) begin
        if (wq.size() == 0 || wq[0] != cyc) chk("unexpected_wr_err", 32'(wr_err), 32'(0));
        else begin
          chk("wr_err", 32'(wr_err), 32'(1));
          void'(wq.pop_front());
        end
      end else if (wq.size() > 0 && wq[0] <= cyc) begin
        chk("missing_wr_err", 32'(wr_err), 32'(1));
        void'(wq.pop_front());
      end
    end
  end

  // Drive one request at a negedge and queue its expected outcome.
  task automatic drive(input vec_t v, input bit track);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    if (track) begin
      if (!v.we) rq.push_back('{due: cyc + 1 + int'(LAT), rdata: v.exp_rdata, err: v.exp_err});
      else if (v.addr >= 6'd48) wq.push_back(cyc + 2);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (rq.size() == 0 && wq.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", 32'(rq.size() + wq.size()), 32'(0));
  endtask

  task automatic wait_init(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (init_done) break;
      @(negedge clk);
    end
    chk(nm, 32'(init_done), 32'(1));
  endtask

  function automatic vec_t rd(input logic [5:0] a, input logic [31:0] d, input logic e);
    return '{we: 1'b0, addr: a, wdata: 32'h0, be: 4'h0, exp_rdata: d, exp_err: e};
  endfunction

  function automatic vec_t wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
    return '{we: 1'b1, addr: a, wdata: d, be: b, exp_rdata: 32'h0, exp_err: 1'b0};
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;

    vt.push_back(rd(6'd47, 32'h0000_0000, 1'b0));
    vt.push_back(wr(6'd17, 32'hDEAD_BEEF, 4'hF));
    vt.push_back(wr(6'd17, 32'h0000_00AA, 4'h1));
    vt.push_back(rd(6'd17, 32'hDEAD_BEAA, 1'b0));
    vt.push_back(wr(6'd5,  32'h1234_5678, 4'hF));
    vt.push_back(rd(6'd5,  32'h1234_5678, 1'b0));
    vt.push_back(wr(6'd50, 32'hFFFF_FFFF, 4'hF));
    vt.push_back(rd(6'd63, 32'h0000_0000, 1'b1));
    vt.push_back(rd(6'd2,  32'h0000_0000, 1'b0));
    vt.push_back(rd(6'd18, 32'h0000_0000, 1'b0));
    vt.push_back(rd(6'd34, 32'h0000_0000, 1'b0));
    vt.push_back(wr(6'd0,  32'h0000_0001, 4'hF));
    vt.push_back(wr(6'd16, 32'h0000_0002, 4'hF));
    vt.push_back(wr(6'd32, 32'h0000_0003, 4'hF));
    vt.push_back(rd(6'd0,  32'h0000_0001, 1'b0));
    vt.push_back(rd(6'd16, 32'h0000_0002, 1'b0));
    vt.push_back(rd(6'd32, 32'h0000_0003, 1'b0));
    vt.push_back(wr(6'd33, 32'hFFFF_FFFF, 4'h0));
    vt.push_back(rd(6'd33, 32'h0000_0000, 1'b0));
    vt.push_back(wr(6'd40, 32'h1122_3344, 4'hA));
    vt.push_back(rd(6'd40, 32'h1100_3300, 1'b0));
    vt.push_back(wr(6'd47, 32'hAABB_CCDD, 4'hC));
    vt.push_back(rd(6'd48, 32'h0000_0000, 1'b1));
    vt.push_back(rd(6'd47, 32'hAABB_0000, 1'b0));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    chk("rst_wr_err", 32'(wr_err), 32'(0));

    // INIT lasts 16 cycles after release
    rst_n = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("init_req_ready", 32'(req_ready), 32'(0));
    end
    @(negedge clk);
    chk("run_req_ready", 32'(req_ready), 32'(1));
    chk("run_init_done", 32'(init_done), 32'(1));

    // Table-driven vectors, back to back
    foreach (vt[i]) drive(vt[i], 1'b1);
    drain();
    chk("rsp_rdata_hold", rsp_rdata, 32'hAABB_0000);

    // Reset while two reads are in flight
    drive(rd(6'd17, 32'hDEAD_BEAA, 1'b0), 1'b1);
    drive(rd(6'd5, 32'h1234_5678, 1'b0), 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rsp_valid_drop", 32'(rsp_valid), 32'(0));
    chk("async_req_ready_drop", 32'(req_ready), 32'(0));
    chk("reset_queue_empty", 32'(rq.size()), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit_done");

    // Memory re-cleared by the second INIT
    drive(rd(6'd17, 32'h0, 1'b0), 1'b1);
    drive(rd(6'd5,  32'h0, 1'b0), 1'b1);
    drive(rd(6'd40, 32'h0, 1'b0), 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
